// File: rtl/flop_chain_serializer_tx_if.sv
// rtl/flop_chain_serializer_tx_if.sv - producer/link bundle for the flop-chain serializer
interface flop_chain_serializer_tx_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, ser_out, ser_valid, frame_start, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ser_out, ser_valid, frame_start, busy
    );
endinterface

// File: rtl/flop_chain_serializer_tx.sv
// rtl/flop_chain_serializer_tx.sv - parallel-in/serial-out link transmitter
// Optional even-parity trailer bit: FLOP_CHAIN_TX_PARITY_EN.
module flop_chain_serializer_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                      clk,
    input logic                      rstn,
    flop_chain_serializer_tx_if.slave bus
);
    localparam int CW    = $clog2(WIDTH);
    localparam int FIRST = MSB_FIRST ? WIDTH - 1 : 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
`ifdef FLOP_CHAIN_TX_PARITY_EN
        , PARITY = 2'd2
`endif
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_rot;
    logic             cnt_zero;
    logic             accept;
`ifdef FLOP_CHAIN_TX_PARITY_EN
    logic             par_bit;
`endif

    assign cnt_zero = (cnt == '0);
    assign accept   = bus.in_valid && bus.in_ready;

    // Rotating keeps every bit live; the bit landing at FIRST is the next one to send.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shreg_rot = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
        end else begin : g_lsb
            assign shreg_rot = {shreg[0], shreg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt_zero) begin
`ifdef FLOP_CHAIN_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef FLOP_CHAIN_TX_PARITY_EN
            PARITY: begin
                state_nxt = accept ? SHIFT : IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = 1'b0;
        case (state)
            IDLE: bus.in_ready = 1'b1;
`ifdef FLOP_CHAIN_TX_PARITY_EN
            SHIFT:  bus.in_ready = 1'b0;
            PARITY: bus.in_ready = 1'b1;
`else
            SHIFT:  bus.in_ready = cnt_zero;
`endif
            default: bus.in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            shreg           <= '0;
            cnt             <= '0;
            bus.ser_out     <= 1'b0;
            bus.ser_valid   <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.busy        <= 1'b0;
`ifdef FLOP_CHAIN_TX_PARITY_EN
            par_bit         <= 1'b0;
`endif
        end else begin
            bus.frame_start <= accept;
            bus.ser_valid   <= (state_nxt != IDLE);
            bus.busy        <= (state_nxt != IDLE);
            if (accept) begin
                shreg       <= bus.in_data;
                cnt         <= CW'(WIDTH - 1);
                bus.ser_out <= bus.in_data[FIRST];
`ifdef FLOP_CHAIN_TX_PARITY_EN
                par_bit     <= ^bus.in_data;
`endif
            end else if (state == SHIFT) begin
                shreg <= shreg_rot;
                if (!cnt_zero) begin
                    cnt         <= cnt - CW'(1);
                    bus.ser_out <= shreg_rot[FIRST];
                end
`ifdef FLOP_CHAIN_TX_PARITY_EN
                else begin
                    bus.ser_out <= par_bit;
                end
`endif
            end
        end
    end
endmodule

// File: doc/flop_chain_serializer_tx.md
Name: flop_chain_serializer_tx

Overview:
- Parallel-in / serial-out transmitter. It is the sending end of the team's flop-chain serial link.
- Captures a WIDTH-bit word through a valid/ready handshake, then shifts it out one bit per clk cycle with a qualifying valid strobe and a frame-start marker.
- Sits between a parallel producer (register bank / FIFO) and the link; the SIPO capture chain on the far end consumes the stream.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  reset, asynchronous, active-high. rstn=1 forces reset immediately, independent of clk.
- in_valid  input  1  producer has a word on in_data.
- in_data  input  WIDTH  parallel word; sampled only on accept.
- in_ready  output  1  transmitter can accept a word this cycle.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- frame_start  output  1  high on the first bit of each frame only.
- busy  output  1  frame in progress (state != IDLE).

Behaviour:
- All outputs are registered except in_ready, which is combinational from state/counter only and never from in_valid.
- Reset values: ser_out=0, ser_valid=0, frame_start=0, busy=0, state=IDLE, shift register=0, bit counter=0. in_ready reads 1 in IDLE.
- Reset asserted mid-frame aborts the frame immediately: ser_valid drops in the same cycle reset asserts, and the word is lost. After reset deasserts, the first accept occurs on the first clk edge with in_valid=1.
- Accept: the in_valid && in_ready sample at a rising edge loads in_data into the shift register. Latency is 1: the first bit appears on ser_out with ser_valid=1 and frame_start=1 in the cycle after the accept edge.
- States:
  - IDLE: in_ready=1. On accept go to SHIFT, counter=WIDTH-1.
  - SHIFT: ser_valid=1. Each edge shifts one bit (left if MSB_FIRST=1, right if 0) and decrements the counter.
  - Exit from SHIFT on the edge where the counter is 0:
    - go to PARITY if PARITY_EN is defined;
    - else go to SHIFT if an accept occurs (back-to-back, new frame, frame_start=1);
    - else go to IDLE.
  - PARITY (only if PARITY_EN is defined): one cycle, ser_valid=1, ser_out=parity bit, in_ready=1. Accept goes to SHIFT, otherwise to IDLE.
- in_ready in SHIFT is 1 only when counter==0 and PARITY_EN is not defined. This gives gapless back-to-back frames: WIDTH consecutive ser_valid cycles per word.
- in_data changes while not accepted have no effect. in_valid held high while in_ready=0 must not cause a re-capture or a dropped word.
- frame_start is never high unless ser_valid is high, and is high for exactly one cycle per frame.
- ser_out is held at its last value when ser_valid=0. Do not toggle it.

Optional Feature:
- Macro FLOP_CHAIN_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of all WIDTH data bits captured at accept) is appended after the last data bit. Frame length becomes WIDTH+1 ser_valid cycles. in_ready is low during the last data bit and high during the parity cycle.
- Undefined: no PARITY state, frames are exactly WIDTH bits, and there is no parity logic.

Test Plan:
- WIDTH=8, MSB_FIRST=1, accept 0xA5 at edge 0 -> ser_out 1,0,1,0,0,1,0,1 on cycles 1..8; ser_valid=1 on cycles 1..8; frame_start=1 on cycle 1 only; busy=0 and in_ready=1 on cycle 9.
- MSB_FIRST=0, accept 0x0D -> ser_out 1,0,1,1,0,0,0,0 on cycles 1..8.
- Back-to-back 0xFF then 0x00, in_valid held high (parity off) -> 16 contiguous ser_valid cycles: 8 ones then 8 zeros; frame_start on cycles 1 and 9; second accept occurs on the cycle-8 edge.
- in_valid held high with 0x3C, then in_data changed to 0xC3 on cycle 3 before in_valid drops -> stream is exactly 0x3C; no second frame unless in_valid is still high at the last-bit edge.
- Assert rstn on cycle 4 of a 0xA5 frame -> ser_valid, busy, frame_start and ser_out are 0 in the same cycle. After release, 0x5A sends correctly starting one cycle after accept.
- FLOP_CHAIN_TX_PARITY_EN defined, 0xA5 then 0x07 -> parity bit 0 on cycle 9 and 1 on cycle 18. in_ready=0 on cycle 8 and 1 on cycle 9.
